sd_tx_mapper: RTL and testbench

Transmit-side companion to the DFS sphere decoder. It accepts one 4-symbol vector of 3-bit indices, maps each index to an 8-PAM level, and multiplies the result by a programmable upper-triangular 4x4 channel matrix R to produce the received vector y = R·s. This is the stimulus/channel source that feeds the decoder. Computation is sequential: one multiply-accumulate per cycle, rows ordered 3→0 to match the decoder's level order.

---
 rtl/sd_tx_mapper.sv | 158 +++++++++++++++
 tb/tb_sd_tx_mapper.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/sd_tx_mapper.sv
// Transmit-side channel source for the sphere decoder: maps four 3-bit indices to
// 8-PAM levels and computes y = R*s with one multiply-accumulate per cycle.
module sd_tx_mapper #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    InValid,
  output logic                    InReady,
  input  logic [2:0]              InData0,
  input  logic [2:0]              InData1,
  input  logic [2:0]              InData2,
  input  logic [2:0]              InData3,
  input  logic                    CoefWe,
  input  logic [3:0]              CoefAddr,
  input  logic signed [WIDTH-1:0] CoefData,
  input  logic                    OutAck,
  output logic signed [WIDTH-1:0] OutData0,
  output logic signed [WIDTH-1:0] OutData1,
  output logic signed [WIDTH-1:0] OutData2,
  output logic signed [WIDTH-1:0] OutData3,
  output logic                    OutputReady,
  output logic [1:0]              CurrentRow
);

  localparam int unsigned NCOEF = 16;
  localparam int unsigned NSYM  = 4;
  localparam int unsigned SYMW  = 4;

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [1:0]        row_q, row_d;
  logic [1:0]        col_q, col_d;
  logic [1:0]        cur_row_q, cur_row_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [SYMW-1:0]   sym_q [NSYM];
  logic [SYMW-1:0]   sym_d [NSYM];
  logic [WIDTH-1:0]  coef_q [NCOEF];
  logic [WIDTH-1:0]  coef_d [NCOEF];
  logic [WIDTH-1:0]  y_q [NSYM];
  logic [WIDTH-1:0]  y_d [NSYM];
  logic              out_ready_q, out_ready_d;

  logic [WIDTH-1:0]  coef_rd;
  logic [SYMW-1:0]   sym_rd;
  logic [WIDTH-1:0]  prod;
  logic [WIDTH-1:0]  acc_next;
  logic              coef_wr_ok;

  // 8-PAM level 2*d - 7 in 4-bit two's complement
  function automatic logic [SYMW-1:0] map_sym(input logic [2:0] d);
    return SYMW'({d, 1'b0}) - SYMW'(7);
  endfunction

  always_comb begin
    coef_rd  = coef_q[{row_q, col_q}];
    sym_rd   = sym_q[col_q];
    // only the low WIDTH bits of the sign-extended product survive the wrap
    prod     = coef_rd * {{(WIDTH-SYMW){sym_rd[SYMW-1]}}, sym_rd};
    acc_next = acc_q + prod;
    coef_wr_ok = CoefWe && (state_q == S_IDLE) && (CoefAddr[1:0] >= CoefAddr[3:2]);

    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    cur_row_d   = cur_row_q;
    acc_d       = acc_q;
    sym_d       = sym_q;
    coef_d      = coef_q;
    y_d         = y_q;
    out_ready_d = out_ready_q;

    if (coef_wr_ok) begin
      coef_d[CoefAddr] = CoefData;
    end

    case (state_q)
      S_IDLE: begin
        if (InValid) begin
          sym_d[0]  = map_sym(InData0);
          sym_d[1]  = map_sym(InData1);
          sym_d[2]  = map_sym(InData2);
          sym_d[3]  = map_sym(InData3);
          row_d     = 2'd3;
          col_d     = 2'd3;
          cur_row_d = 2'd3;
          acc_d     = '0;
          state_d   = S_MAC;
        end
      end
      S_MAC: begin
        if (col_q == 2'd3) begin
          y_d[row_q] = acc_next;
          acc_d      = '0;
          if (row_q == 2'd0) begin
            state_d     = S_DONE;
            out_ready_d = 1'b1;
            cur_row_d   = 2'd0;
            col_d       = 2'd0;
          end else begin
            // next row starts on its diagonal
            row_d     = row_q - 2'd1;
            col_d     = row_q - 2'd1;
            cur_row_d = row_q - 2'd1;
          end
        end else begin
          acc_d = acc_next;
          col_d = col_q + 2'd1;
        end
      end
      S_DONE: begin
        if (OutAck) begin
          state_d     = S_IDLE;
          out_ready_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= S_IDLE;
      row_q       <= '0;
      col_q       <= '0;
      cur_row_q   <= '0;
      acc_q       <= '0;
      out_ready_q <= 1'b0;
      for (int i = 0; i < NSYM; i++) begin
        sym_q[i] <= '0;
        y_q[i]   <= '0;
      end
      for (int i = 0; i < NCOEF; i++) begin
        coef_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      cur_row_q   <= cur_row_d;
      acc_q       <= acc_d;
      out_ready_q <= out_ready_d;
      sym_q       <= sym_d;
      y_q         <= y_d;
      coef_q      <= coef_d;
    end
  end

  assign InReady     = (state_q == S_IDLE);
  assign OutputReady = out_ready_q;
  assign CurrentRow  = cur_row_q;
  assign OutData0    = y_q[0];
  assign OutData1    = y_q[1];
  assign OutData2    = y_q[2];
  assign OutData3    = y_q[3];

endmodule

// File: tb/tb_sd_tx_mapper.sv
// Directed bench for sd_tx_mapper: 32-bit instance for function/protocol, 8-bit for wrap.
module tb_sd_tx_mapper;

  logic               Clk;
  logic               Reset;
  logic               InValid, InReady;
  logic [2:0]         InData0, InData1, InData2, InData3;
  logic               CoefWe;
  logic [3:0]         CoefAddr;
  logic signed [31:0] CoefData;
  logic               OutAck;
  logic signed [31:0] OutData0, OutData1, OutData2, OutData3;
  logic               OutputReady;
  logic [1:0]         CurrentRow;

  logic               b_InValid, b_InReady;
  logic [2:0]         b_InData0;
  logic               b_CoefWe;
  logic [3:0]         b_CoefAddr;
  logic signed [7:0]  b_CoefData;
  logic               b_OutAck;
  logic signed [7:0]  b_OutData0, b_OutData1, b_OutData2, b_OutData3;
  logic               b_OutputReady;
  logic [1:0]         b_CurrentRow;

  int n_vec = 0;
  int n_err = 0;
  int crow [10];
  int exp_crow [10] = '{3, 2, 2, 1, 1, 1, 0, 0, 0, 0};
  int lat;

  sd_tx_mapper #(.WIDTH(32)) dut (
    .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(InReady),
    .InData0(InData0), .InData1(InData1), .InData2(InData2), .InData3(InData3),
    .CoefWe(CoefWe), .CoefAddr(CoefAddr), .CoefData(CoefData), .OutAck(OutAck),
    .OutData0(OutData0), .OutData1(OutData1), .OutData2(OutData2), .OutData3(OutData3),
    .OutputReady(OutputReady), .CurrentRow(CurrentRow)
  );

  sd_tx_mapper #(.WIDTH(8)) dut8 (
    .Clk(Clk), .Reset(Reset), .InValid(b_InValid), .InReady(b_InReady),
    .InData0(b_InData0), .InData1(3'd0), .InData2(3'd0), .InData3(3'd0),
    .CoefWe(b_CoefWe), .CoefAddr(b_CoefAddr), .CoefData(b_CoefData), .OutAck(b_OutAck),
    .OutData0(b_OutData0), .OutData1(b_OutData1), .OutData2(b_OutData2), .OutData3(b_OutData3),
    .OutputReady(b_OutputReady), .CurrentRow(b_CurrentRow)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input longint v);
    CoefWe = 1'b1; CoefAddr = a; CoefData = 32'(v);
    @(negedge Clk);
    CoefWe = 1'b0;
  endtask

  task automatic wr_identity();
    for (int r = 0; r < 4; r++)
      for (int c = r; c < 4; c++)
        wr(4'(r * 4 + c), (r == c) ? 1 : 0);
  endtask

  task automatic ack();
    OutAck = 1'b1;
    @(negedge Clk);
    OutAck = 1'b0;
  endtask

  task automatic check_y(input string tag, input longint y0, input longint y1,
                         input longint y2, input longint y3);
    check({tag, "_y0"}, OutData0, y0);
    check({tag, "_y1"}, OutData1, y1);
    check({tag, "_y2"}, OutData2, y2);
    check({tag, "_y3"}, OutData3, y3);
  endtask

  // Accept a vector, optionally writing a coefficient at the accept edge or the first
  // MAC edge, then wait (bounded) for OutputReady while tracing CurrentRow.
  task automatic run_vec(input logic [2:0] d0, input logic [2:0] d1, input logic [2:0] d2,
                         input logic [2:0] d3, input bit wr_acc, input bit wr_mac,
                         input logic [3:0] wa, input longint wd, output int latency);
    int cnt;
    @(negedge Clk);
    check("in_ready_idle", InReady, 1);
    InValid = 1'b1;
    InData0 = d0; InData1 = d1; InData2 = d2; InData3 = d3;
    if (wr_acc) begin CoefWe = 1'b1; CoefAddr = wa; CoefData = 32'(wd); end
    @(negedge Clk);
    InValid = 1'b0;
    CoefWe  = 1'b0;
    if (wr_mac) begin CoefWe = 1'b1; CoefAddr = wa; CoefData = 32'(wd); end
    check("in_ready_mac", InReady, 0);
    cnt = 1;
    while (!OutputReady && cnt <= 40) begin
      if (cnt <= 10) crow[cnt-1] = CurrentRow;
      @(negedge Clk);
      CoefWe = 1'b0;
      cnt++;
    end
    latency = cnt - 1;
    if (!OutputReady) check("out_ready_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b0; InValid = 1'b0; OutAck = 1'b0; CoefWe = 1'b0;
    InData0 = '0; InData1 = '0; InData2 = '0; InData3 = '0;
    CoefAddr = '0; CoefData = '0;
    b_InValid = 1'b0; b_InData0 = '0; b_CoefWe = 1'b0; b_CoefAddr = '0;
    b_CoefData = '0; b_OutAck = 1'b0;
    repeat (3) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    check("rst_in_ready", InReady, 1);
    check("rst_out_ready", OutputReady, 0);
    check("rst_cur_row", CurrentRow, 0);
    check_y("rst", 0, 0, 0, 0);

    // Identity R: latency and row trace
    wr(4'h0, 1); wr(4'h5, 1); wr(4'hA, 1); wr(4'hF, 1);
    run_vec(3'd0, 3'd7, 3'd3, 3'd4, 1'b0, 1'b0, 4'h0, 0, lat);
    check("ident_latency", lat, 10);
    for (int i = 0; i < 10; i++) check($sformatf("ident_crow%0d", i), crow[i], exp_crow[i]);
    check("done_cur_row", CurrentRow, 0);
    check_y("ident", -7, 7, -1, 1);
    ack();

    // All-ones upper triangle
    for (int r = 0; r < 4; r++)
      for (int c = r; c < 4; c++) wr(4'(r * 4 + c), 1);
    run_vec(3'd7, 3'd7, 3'd7, 3'd7, 1'b0, 1'b0, 4'h0, 0, lat);
    check_y("ones", 28, 21, 14, 7);
    ack();
    // -3 in the last column of rows 2 and 0
    wr(4'b1011, -3); wr(4'b0011, -3);
    run_vec(3'd7, 3'd7, 3'd7, 3'd7, 1'b0, 1'b0, 4'h0, 0, lat);
    check_y("neg3", 0, 21, -14, 7);
    ack();

    // Lower-triangle write dropped; write during MAC dropped for this and next vector
    wr_identity();
    wr(4'b0100, 5);
    run_vec(3'd7, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1, 4'b0101, 9, lat);
    check_y("lower", 7, -7, -7, -7);
    ack();
    run_vec(3'd7, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 4'h0, 0, lat);
    check("mac_wr_next_y1", OutData1, -7);
    ack();

    // Coefficient write coincident with accept is used by that vector
    run_vec(3'd0, 3'd0, 3'd0, 3'd7, 1'b1, 1'b0, 4'hF, 3, lat);
    check("same_edge_y3", OutData3, 21);
    check("same_edge_y0", OutData0, -7);

    // Backpressure: hold in DONE, InValid pulses ignored
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      InValid = i[0];
      InData0 = 3'd3;
      check("bp_out_ready", OutputReady, 1);
      check("bp_in_ready", InReady, 0);
      check("bp_y3", OutData3, 21);
      check("bp_y0", OutData0, -7);
    end
    InValid = 1'b0;
    @(negedge Clk);
    ack();
    check("ack_in_ready", InReady, 1);
    check("ack_out_ready", OutputReady, 0);
    check("ack_y3_held", OutData3, 21);
    run_vec(3'd1, 3'd1, 3'd1, 3'd1, 1'b0, 1'b0, 4'h0, 0, lat);
    check_y("after_bp", -5, -5, -5, -15);
    ack();

    // Async reset mid-MAC
    @(negedge Clk);
    InValid = 1'b1;
    InData0 = 3'd7; InData1 = 3'd7; InData2 = 3'd7; InData3 = 3'd7;
    @(negedge Clk);
    InValid = 1'b0;
    repeat (4) @(negedge Clk);
    #2 Reset = 1'b0;
    #1;
    check("mid_rst_out_ready", OutputReady, 0);
    check("mid_rst_in_ready", InReady, 1);
    check("mid_rst_cur_row", CurrentRow, 0);
    check_y("mid_rst", 0, 0, 0, 0);
    @(negedge Clk);
    Reset = 1'b1;
    run_vec(3'd7, 3'd7, 3'd7, 3'd7, 1'b0, 1'b0, 4'h0, 0, lat);
    check_y("coef_cleared", 0, 0, 0, 0);
    ack();
    wr(4'h0, 1); wr(4'h5, 1); wr(4'hA, 1); wr(4'hF, 1);
    run_vec(3'd0, 3'd7, 3'd3, 3'd4, 1'b0, 1'b0, 4'h0, 0, lat);
    check("post_rst_latency", lat, 10);
    check_y("post_rst", -7, 7, -1, 1);
    ack();

    // 8-bit instance: 100 * 7 wraps to -68
    @(negedge Clk);
    b_CoefWe = 1'b1; b_CoefAddr = 4'h0; b_CoefData = 8'sd100;
    @(negedge Clk);
    b_CoefWe = 1'b0;
    b_InValid = 1'b1; b_InData0 = 3'd7;
    @(negedge Clk);
    b_InValid = 1'b0;
    for (int i = 0; i < 40 && !b_OutputReady; i++) @(negedge Clk);
    check("w8_out_ready", b_OutputReady, 1);
    check("w8_y0_wrap", b_OutData0, -68);
    check("w8_y1", b_OutData1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
